// File: rtl/shreg_pkg.sv
// shreg_pkg: state encoding shared by the shift/load register and its bench-facing top.
`default_nettype none

package shreg_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shreg_bit.sv
// shreg_bit: one register bit, asynchronous active-low reset, hold / load / shift-in select.
`default_nettype none

module shreg_bit
  import shreg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic shift,
  input  logic load_val,
  input  logic shift_val,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= shift_val;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_load_register.sv
// shift_load_register: load a word, shift it right SHIFTS times, pulse done.
// SHREG_ROTATE_EN defined: shifts rotate dout[0] into the MSB and ser_in is ignored.
`default_nettype none

module shift_load_register
  import shreg_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SHIFTS = 8,
  parameter int CNT_W  = $clog2(SHIFTS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             ser_in,
  output logic [WIDTH-1:0] dout,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SHIFTS - 1);

  state_t state;
  state_t next_state;
  logic   load_en;
  logic   shift_en;
  logic   msb_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_LOAD;
      end
      S_LOAD: begin
        load_en    = 1'b1;
        next_state = S_SHIFT;
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        if (count == LAST_SHIFT) next_state = S_DONE;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Counter holds its final value (SHIFTS) through DONE and IDLE until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load_en) begin
      count <= '0;
    end else if (shift_en) begin
      count <= count + CNT_W'(1);
    end
  end

`ifdef SHREG_ROTATE_EN
  logic unused_ser_in;
  assign unused_ser_in = ser_in;
  assign msb_in        = dout[0];
`else
  assign msb_in = ser_in;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    logic shift_val;
    if (i == WIDTH - 1) begin : g_msb
      assign shift_val = msb_in;
    end else begin : g_low
      assign shift_val = dout[i+1];
    end

    shreg_bit u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_en),
      .shift     (shift_en),
      .load_val  (din[i]),
      .shift_val (shift_val),
      .q         (dout[i])
    );
  end

  assign ser_out = dout[0];
  assign busy    = (state == S_LOAD) || (state == S_SHIFT);
  assign done    = (state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_shift_load_register.sv
// tb_shift_load_register: randomized self-checking bench for shift_load_register.
`default_nettype none

module tb_shift_load_register;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Instance with SHIFTS = 8
  logic       start, ser_in;
  logic [7:0] din, dout;
  logic       ser_out, busy, done;
  logic [3:0] count;

  // Instance with SHIFTS = 3
  logic       start3, ser_in3;
  logic [7:0] din3, dout3;
  logic       ser_out3, busy3, done3;
  logic [1:0] count3;

  // Instance with SHIFTS = 1
  logic       start1, ser_in1;
  logic [7:0] din1, dout1;
  logic       ser_out1, busy1, done1;
  logic [0:0] count1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_load_register #(.WIDTH(8), .SHIFTS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .ser_in(ser_in),
    .dout(dout), .ser_out(ser_out), .busy(busy), .done(done), .count(count)
  );

  shift_load_register #(.WIDTH(8), .SHIFTS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .din(din3), .ser_in(ser_in3),
    .dout(dout3), .ser_out(ser_out3), .busy(busy3), .done(done3), .count(count3)
  );

  shift_load_register #(.WIDTH(8), .SHIFTS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .din(din1), .ser_in(ser_in1),
    .dout(dout1), .ser_out(ser_out1), .busy(busy1), .done(done1), .count(count1)
  );

  // Result after s shifts: bit j of sp is the serial bit applied on shift j.
  function automatic logic [7:0] model(input logic [7:0] d, input logic [7:0] sp, input int s);
    int r;
`ifdef SHREG_ROTATE_EN
    r = ((int'(d) >> s) | (int'(d) << (8 - s))) & 255;
    if (sp == 8'hxx) r = 0;
`else
    r = (int'(d) >> s) | ((int'(sp) & ((1 << s) - 1)) << (8 - s));
`endif
    return r[7:0];
  endfunction

  task automatic test_reset();
    int waited;
    #2;
    vectors++;
    if ({dout, ser_out, busy, done, count} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_init dout=%h ser_out=%b busy=%b done=%b count=%0d exp all 0",
               dout, ser_out, busy, done, count);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) begin start = 1'b1; din = 8'($urandom); end
    @(negedge clk) start = 1'b0;
    waited = 0;
    while (!(busy === 1'b1 && count === 4'd3) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (!(busy === 1'b1 && count === 4'd3)) begin
      miscompares++;
      $display("FAIL reset_reach_count3 busy=%b count=%0d exp busy=1 count=3", busy, count);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({dout, ser_out, busy, done, count} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_async dout=%h ser_out=%b busy=%b done=%b count=%0d exp all 0",
               dout, ser_out, busy, done, count);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({dout, busy, done, count} !== 14'd0) begin
        miscompares++;
        $display("FAIL reset_idle dout=%h busy=%b done=%b count=%0d exp all 0",
                 dout, busy, done, count);
      end
    end
  endtask

  // One full operation on the SHIFTS=8 instance; restart_k >= 0 re-pulses start during that shift.
  task automatic run_op(input logic [7:0] d, input logic [7:0] sp, input int restart_k,
                        input string tag);
    logic [7:0] exp;
    exp = model(d, sp, 8);
    @(negedge clk) begin start = 1'b1; din = d; end
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL %s load_state busy=%b done=%b exp busy=1 done=0", tag, busy, done);
    end
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (dout !== d) begin
      miscompares++;
      $display("FAIL %s loaded dout=%h exp %h", tag, dout, d);
    end
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if ({busy, done, count, ser_out} !== {2'b10, 4'(j), d[j]}) begin
        miscompares++;
        $display("FAIL %s shift%0d busy=%b done=%b count=%0d ser_out=%b exp busy=1 done=0 count=%0d ser_out=%b",
                 tag, j, busy, done, count, ser_out, j, d[j]);
      end
      ser_in = sp[j];
      if (j == restart_k) begin start = 1'b1; din = 8'hFF; end
      else begin start = 1'b0; din = d; end
      @(negedge clk);
    end
    start = 1'b0;
    din = d;
    vectors++;
    if ({done, busy, count, dout, ser_out} !== {2'b10, 4'd8, exp, exp[0]}) begin
      miscompares++;
      $display("FAIL %s done_cycle done=%b busy=%b count=%0d dout=%h ser_out=%b exp done=1 busy=0 count=8 dout=%h",
               tag, done, busy, count, dout, ser_out, exp);
    end
    @(negedge clk);
    vectors++;
    if ({done, busy, dout} !== {2'b00, exp}) begin
      miscompares++;
      $display("FAIL %s after_done done=%b busy=%b dout=%h exp done=0 busy=0 dout=%h",
               tag, done, busy, dout, exp);
    end
  endtask

  task automatic test_basic();
    run_op(8'hB5, 8'h00, -1, "basic");
  endtask

  task automatic test_fill();
    run_op(8'h00, 8'hFF, -1, "fill");
  endtask

  task automatic test_ignored_start();
    run_op(8'h3C, 8'h00, 2, "ignored_start");
    repeat (10) begin
      @(negedge clk);
      vectors++;
      if ({done, busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL ignored_start_queued done=%b busy=%b exp 0 0", done, busy);
      end
    end
  endtask

  task automatic test_rotate_or_serial();
    run_op(8'hA7, 8'h55, -1, "rotate_toggle");
  endtask

  task automatic test_random();
    repeat (12) run_op(8'($urandom), 8'($urandom), -1, "random");
  endtask

  task automatic test_single_shift();
    logic [7:0] d, sp;
    d  = 8'($urandom);
    sp = 8'($urandom);
    @(negedge clk) begin start1 = 1'b1; din1 = d; ser_in1 = sp[0]; end
    @(negedge clk) start1 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy1, count1, dout1} !== {1'b1, 1'b0, d}) begin
      miscompares++;
      $display("FAIL single_shift_loaded busy=%b count=%0d dout=%h exp busy=1 count=0 dout=%h",
               busy1, count1, dout1, d);
    end
    @(negedge clk);
    vectors++;
    if ({done1, busy1, count1, dout1} !== {2'b10, 1'b1, model(d, sp, 1)}) begin
      miscompares++;
      $display("FAIL single_shift_done done=%b busy=%b count=%0d dout=%h exp done=1 busy=0 count=1 dout=%h",
               done1, busy1, count1, dout1, model(d, sp, 1));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int pulses, last;
    logic [7:0] exp;
    exp = model(8'h80, 8'h00, 3);
    pulses = 0;
    last = -1;
    @(negedge clk) begin start3 = 1'b1; din3 = 8'h80; ser_in3 = 1'b0; end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done3 === 1'b1) begin
        pulses++;
        vectors++;
        if ({dout3, count3} !== {exp, 2'd3}) begin
          miscompares++;
          $display("FAIL b2b_result cycle%0d dout=%h count=%0d exp dout=%h count=3",
                   c, dout3, count3, exp);
        end
        if (last >= 0) begin
          vectors++;
          if (c - last !== 6) begin
            miscompares++;
            $display("FAIL b2b_spacing got %0d cycles exp 6", c - last);
          end
        end
        last = c;
      end
    end
    vectors++;
    if (pulses !== 6) begin
      miscompares++;
      $display("FAIL b2b_pulse_count got %0d exp 6", pulses);
    end
    start3 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    start = 1'b0;  din = 8'h00;  ser_in = 1'b0;
    start3 = 1'b0; din3 = 8'h00; ser_in3 = 1'b0;
    start1 = 1'b0; din1 = 8'h00; ser_in1 = 1'b0;
    test_reset();
    test_basic();
    test_fill();
    test_ignored_start();
    test_rotate_or_serial();
    test_random();
    test_single_shift();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
